// File: rtl/ctrl_pkg.sv
// Shared types and constants for the vector control sequencer: opcode map,
// FSM state encoding and the decoded control bundle.
package ctrl_pkg;

  localparam logic [2:0] OP_ALUR   = 3'b000;
  localparam logic [2:0] OP_ALUI   = 3'b001;
  localparam logic [2:0] OP_LOAD   = 3'b010;
  localparam logic [2:0] OP_STORE  = 3'b011;
  localparam logic [2:0] OP_BRANCH = 3'b100;
  localparam logic [2:0] OP_JUMP   = 3'b101;
  localparam logic [2:0] OP_NOP    = 3'b110;
  localparam logic [2:0] OP_HALT   = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  // branch marks ops whose PCSrc follows the live zero flag
  typedef struct packed {
    logic       pcSrc;
    logic       branch;
    logic       regWrite;
    logic       immSrc;
    logic       aluSrc;
    logic       memWrite;
    logic       memRead;
    logic       memtoReg;
    logic [2:0] aluOp;
  } ctrl_t;

  // Only the ALU and memory opcodes (MSB clear) have a vector form.
  function automatic logic vecCapable(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic state_t entryState(input logic [2:0] op);
    if (op == OP_HALT) return ST_HALT;
    if (op == OP_LOAD || op == OP_STORE) return ST_MEM;
    return ST_EXEC;
  endfunction

endpackage

// File: rtl/vector_control_sequencer_if.sv
// Instruction handshake, datapath controls and sequencing status between the
// decode stage, the sequencer and the scalar/vector datapath.
interface vector_control_sequencer_if #(
  parameter int LANES   = 4,
  parameter int VLEN    = 16,
  parameter int ALUOP_W = 3
);
  localparam int BEATS  = VLEN / LANES;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic               instr_valid;
  logic               instr_ready;
  logic [2:0]         opcode;
  logic [2:0]         funct;
  logic               vec;
  logic               zero_flag;
  logic               mem_ready;
  logic               PCSrc;
  logic               RegWrite;
  logic               ImmSrc;
  logic               ALUSrc;
  logic               MemWrite;
  logic               MemRead;
  logic               MemtoReg;
  logic [ALUOP_W-1:0] AluOp;
  logic               vec_active;
  logic [BIDX_W-1:0]  beat_idx;
  logic               busy;
  logic               done;
  logic               halted;

  modport master (
    output instr_valid, opcode, funct, vec, zero_flag, mem_ready,
    input  instr_ready, PCSrc, RegWrite, ImmSrc, ALUSrc, MemWrite, MemRead, MemtoReg,
    input  AluOp, vec_active, beat_idx, busy, done, halted
  );

  modport slave (
    input  instr_valid, opcode, funct, vec, zero_flag, mem_ready,
    output instr_ready, PCSrc, RegWrite, ImmSrc, ALUSrc, MemWrite, MemRead, MemtoReg,
    output AluOp, vec_active, beat_idx, busy, done, halted
  );

endinterface

// File: rtl/ctrl_decoder.sv
// Pure combinational opcode/funct decode into the control bundle that the
// sequencer latches when it accepts an instruction.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [2:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl       = '0;
    ctrl.aluOp = ALU_ADD;
    case (opcode)
      OP_ALUR: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluOp    = funct;
      end
      OP_ALUI: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.immSrc   = 1'b1;
        ctrl.aluOp    = funct;
      end
      // RegWrite for a load is further qualified by mem_ready in the sequencer
      OP_LOAD: begin
        ctrl.memRead  = 1'b1;
        ctrl.memtoReg = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      OP_STORE:  ctrl.memWrite = 1'b1;
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.aluOp  = ALU_SUB;
      end
      OP_JUMP:   ctrl.pcSrc = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/vector_control_sequencer.sv
// Multi-cycle control sequencer: latches decoded controls on acceptance and
// steps scalar or vector instructions through their beats.
module vector_control_sequencer
  import ctrl_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int VLEN    = 16,
  parameter int ALUOP_W = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  vector_control_sequencer_if.slave   bus
);

  localparam int BEATS  = VLEN / LANES;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS - 1);

  state_t            stateReg;
  ctrl_t             ctrlReg;
  ctrl_t             decoded;
  logic              vecReg;
  logic [BIDX_W-1:0] beatReg;
  logic              doneReg;

  logic inExec;
  logic inMem;
  logic active;
  logic retire;
  logic lastBeat;

  ctrl_decoder uDecoder (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .ctrl   (decoded)
  );

  assign inExec   = (stateReg == ST_EXEC);
  assign inMem    = (stateReg == ST_MEM);
  assign active   = inExec | inMem;
  assign retire   = inExec | (inMem & bus.mem_ready);
  assign lastBeat = ~vecReg | (beatReg == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= ST_IDLE;
      ctrlReg  <= '0;
      vecReg   <= 1'b0;
      beatReg  <= '0;
      doneReg  <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            ctrlReg  <= decoded;
            vecReg   <= bus.vec & vecCapable(bus.opcode);
            beatReg  <= '0;
            stateReg <= entryState(bus.opcode);
          end
        end
        ST_EXEC, ST_MEM: begin
          if (retire) begin
            if (lastBeat) begin
              stateReg <= ST_IDLE;
              ctrlReg  <= '0;
              vecReg   <= 1'b0;
              beatReg  <= '0;
              doneReg  <= 1'b1;
            end else begin
              beatReg <= beatReg + 1'b1;
            end
          end
        end
        ST_HALT: ;
      endcase
    end
  end

  // Branch outcome and load write-back follow their live qualifiers within the beat.
  assign bus.PCSrc    = active & (ctrlReg.pcSrc | (ctrlReg.branch & bus.zero_flag));
  assign bus.RegWrite = active & ctrlReg.regWrite & (inExec | bus.mem_ready);
  assign bus.ImmSrc   = active & ctrlReg.immSrc;
  assign bus.ALUSrc   = active & ctrlReg.aluSrc;
  assign bus.MemWrite = active & ctrlReg.memWrite;
  assign bus.MemRead  = active & ctrlReg.memRead;
  assign bus.MemtoReg = active & ctrlReg.memtoReg;
  assign bus.AluOp    = active ? ALUOP_W'(ctrlReg.aluOp) : '0;

  assign bus.instr_ready = (stateReg == ST_IDLE);
  assign bus.busy        = (stateReg != ST_IDLE);
  assign bus.halted      = (stateReg == ST_HALT);
  assign bus.done        = doneReg;
  assign bus.vec_active  = vecReg;
  assign bus.beat_idx    = beatReg;

endmodule
